// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch redirect,
// multi-cycle data access with timeout, and trap / debug-halt entry.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT        = 16,
  parameter int unsigned CNT_WIDTH          = 8,
  parameter int unsigned GPR_ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH_ISA_EXP = 4,
  parameter int unsigned PC_WIDTH           = 32,
  parameter logic        GPR_WRITE          = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_en,
  input  logic [GPR_ADDR_WIDTH-1:0]     if_rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0]     if_rs2_addr,
  input  logic                          if_rs1_used,
  input  logic                          if_rs2_used,
  input  logic                          id_en,
  input  logic                          id_is_load,
  input  logic                          id_gpr_we_n,
  input  logic [GPR_ADDR_WIDTH-1:0]     id_dst_addr,
  input  logic                          id_branch_taken,
  input  logic                          ex_en,
  input  logic                          ex_memory_rd_en,
  input  logic                          ex_memory_we_en,
  input  logic [DATA_WIDTH_ISA_EXP-1:0] ex_exp_code,
  input  logic                          ex_ecall_en,
  input  logic                          ex_ebreak_en,
  input  logic [PC_WIDTH-1:0]           ex_pc,
  input  logic                          dmem_ack,
  input  logic                          trap_ack,
  input  logic                          dbg_halt_en,
  input  logic                          dbg_resume,
  output logic                          pc_stall,
  output logic                          if_stall,
  output logic                          id_stall,
  output logic                          ex_stall,
  output logic                          mem_stall,
  output logic                          if_flush,
  output logic                          id_flush,
  output logic                          ex_flush,
  output logic                          mem_flush,
  output logic                          dmem_req,
  output logic                          trap_req,
  output logic [3:0]                    trap_cause,
  output logic [PC_WIDTH-1:0]           trap_pc,
  output logic                          halted
);

  localparam logic [3:0] CAUSE_EXP    = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK = 4'd3;
  localparam logic [3:0] CAUSE_LDFLT  = 4'd5;
  localparam logic [3:0] CAUSE_STFLT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL  = 4'd11;

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP_WAIT, HALT} state_t;

  state_t                 state, state_nx;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nx;
  logic                   trap_req_nx, halted_nx;
  logic [3:0]             trap_cause_nx;
  logic [PC_WIDTH-1:0]    trap_pc_nx;

  logic trap_hit, mem_hit, br_hit, lu_hit, rs1_hit, rs2_hit;

  // Hazard detection on the current pipeline contents
  assign trap_hit = ex_en && ((ex_exp_code != '0) || ex_ecall_en || ex_ebreak_en);
  assign mem_hit  = ex_en && (ex_memory_rd_en || ex_memory_we_en);
  assign br_hit   = id_en && id_branch_taken;
  assign rs1_hit  = if_rs1_used && (if_rs1_addr == id_dst_addr);
  assign rs2_hit  = if_rs2_used && (if_rs2_addr == id_dst_addr);
  assign lu_hit   = id_en && id_is_load && (id_gpr_we_n == GPR_WRITE) &&
                    (id_dst_addr != '0) && (rs1_hit || rs2_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      trap_req   <= 1'b0;
      trap_cause <= 4'd0;
      trap_pc    <= '0;
      halted     <= 1'b0;
    end else if (cpu_en) begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      trap_req   <= trap_req_nx;
      trap_cause <= trap_cause_nx;
      trap_pc    <= trap_pc_nx;
      halted     <= halted_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    trap_req_nx   = trap_req;
    trap_cause_nx = trap_cause;
    trap_pc_nx    = trap_pc;
    halted_nx     = halted;
    pc_stall      = 1'b0;
    if_stall      = 1'b0;
    id_stall      = 1'b0;
    ex_stall      = 1'b0;
    mem_stall     = 1'b0;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    ex_flush      = 1'b0;
    mem_flush     = 1'b0;
    dmem_req      = 1'b0;

    case (state)
      RUN: begin
        if (trap_hit) begin
          pc_stall   = 1'b1;
          if_flush   = 1'b1;
          id_flush   = 1'b1;
          ex_flush   = 1'b1;
          mem_flush  = 1'b1;
          trap_pc_nx = ex_pc;
          trap_cause_nx = ex_ebreak_en ? CAUSE_EBREAK :
                          ex_ecall_en  ? CAUSE_ECALL  : CAUSE_EXP;
          if (ex_ebreak_en && dbg_halt_en) begin
            halted_nx = 1'b1;
            state_nx  = HALT;
          end else begin
            trap_req_nx = 1'b1;
            state_nx    = TRAP_WAIT;
          end
        end else if (mem_hit) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            pc_stall  = 1'b1;
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_flush = 1'b1;
            cnt_nx    = CNT_WIDTH'(1);
            state_nx  = MEM_WAIT;
          end
        end else if (br_hit) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (lu_hit) begin
          pc_stall = 1'b1;
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        // A late ack wins over the timeout fault in the same cycle
        if (dmem_ack) begin
          dmem_req = 1'b1;
          cnt_nx   = '0;
          state_nx = RUN;
        end else if (cnt == CNT_WIDTH'(MEM_TIMEOUT)) begin
          if_flush      = 1'b1;
          id_flush      = 1'b1;
          ex_flush      = 1'b1;
          mem_flush     = 1'b1;
          trap_cause_nx = ex_memory_rd_en ? CAUSE_LDFLT : CAUSE_STFLT;
          trap_pc_nx    = ex_pc;
          trap_req_nx   = 1'b1;
          cnt_nx        = '0;
          state_nx      = TRAP_WAIT;
        end else begin
          dmem_req  = 1'b1;
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_flush = 1'b1;
          cnt_nx    = cnt + CNT_WIDTH'(1);
        end
      end

      TRAP_WAIT: begin
        pc_stall  = 1'b1;
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        if (trap_ack) begin
          trap_req_nx = 1'b0;
          state_nx    = RUN;
        end
      end

      HALT: begin
        pc_stall  = 1'b1;
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        if (dbg_resume) begin
          halted_nx = 1'b0;
          state_nx  = RUN;
        end
      end

      default: state_nx = RUN;
    endcase

    if (!cpu_en) dmem_req = 1'b0;

    // Reset must silence the combinational controls immediately
    if (!rst_n) begin
      pc_stall  = 1'b0;
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      mem_stall = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
      dmem_req  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk, rst_n, cpu_en;
  logic [4:0]  if_rs1_addr, if_rs2_addr, id_dst_addr;
  logic        if_rs1_used, if_rs2_used;
  logic        id_en, id_is_load, id_gpr_we_n, id_branch_taken;
  logic        ex_en, ex_memory_rd_en, ex_memory_we_en;
  logic [3:0]  ex_exp_code;
  logic        ex_ecall_en, ex_ebreak_en;
  logic [31:0] ex_pc;
  logic        dmem_ack, trap_ack, dbg_halt_en, dbg_resume;
  logic        pc_stall, if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        dmem_req, trap_req, halted;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int n;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en),
    .if_rs1_addr(if_rs1_addr), .if_rs2_addr(if_rs2_addr),
    .if_rs1_used(if_rs1_used), .if_rs2_used(if_rs2_used),
    .id_en(id_en), .id_is_load(id_is_load), .id_gpr_we_n(id_gpr_we_n),
    .id_dst_addr(id_dst_addr), .id_branch_taken(id_branch_taken),
    .ex_en(ex_en), .ex_memory_rd_en(ex_memory_rd_en), .ex_memory_we_en(ex_memory_we_en),
    .ex_exp_code(ex_exp_code), .ex_ecall_en(ex_ecall_en), .ex_ebreak_en(ex_ebreak_en),
    .ex_pc(ex_pc), .dmem_ack(dmem_ack), .trap_ack(trap_ack),
    .dbg_halt_en(dbg_halt_en), .dbg_resume(dbg_resume),
    .pc_stall(pc_stall), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .dmem_req(dmem_req), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] stl = {pc_stall, if_stall, id_stall, ex_stall, mem_stall};
  wire [3:0] fl  = {if_flush, id_flush, ex_flush, mem_flush};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_en = 1'b1;
    if_rs1_addr = '0; if_rs2_addr = '0; if_rs1_used = 1'b0; if_rs2_used = 1'b0;
    id_en = 1'b0; id_is_load = 1'b0; id_gpr_we_n = 1'b1; id_dst_addr = '0;
    id_branch_taken = 1'b0;
    ex_en = 1'b0; ex_memory_rd_en = 1'b0; ex_memory_we_en = 1'b0;
    ex_exp_code = '0; ex_ecall_en = 1'b0; ex_ebreak_en = 1'b0; ex_pc = '0;
    dmem_ack = 1'b0; trap_ack = 1'b0; dbg_halt_en = 1'b0; dbg_resume = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic load_use(input logic [4:0] dst, input logic rs2_used);
    idle();
    id_en = 1'b1; id_is_load = 1'b1; id_gpr_we_n = 1'b0; id_dst_addr = dst;
    if_rs1_addr = 5'd5; if_rs1_used = 1'b1;
    if_rs2_addr = 5'd7; if_rs2_used = rs2_used;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    look();
    check("rst_stl", 64'(stl), 64'h0);
    check("rst_fl", 64'(fl), 64'h0);
    check("rst_trap_req", 64'(trap_req), 64'h0);
    check("rst_cause", 64'(trap_cause), 64'h0);
    check("rst_pc", 64'(trap_pc), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use: one bubble, then normal flow
    load_use(5'd5, 1'b0); look();
    check("lu_stl", 64'(stl), 64'b11000);
    check("lu_fl", 64'(fl), 64'b0100);
    tick();
    idle(); look();
    check("lu_after", 64'(stl), 64'h0);
    load_use(5'd0, 1'b0); look();
    check("lu_x0", 64'(stl), 64'h0);
    load_use(5'd7, 1'b0); look();
    check("lu_rs2_unused", 64'(stl), 64'h0);
    load_use(5'd7, 1'b1); look();
    check("lu_rs2", 64'(stl), 64'b11000);
    load_use(5'd5, 1'b0); id_gpr_we_n = 1'b1; look();
    check("lu_nowe", 64'(stl), 64'h0);
    load_use(5'd5, 1'b0); id_branch_taken = 1'b1; look();
    check("br_stl", 64'(stl), 64'h0);
    check("br_fl", 64'(fl), 64'b1100);
    tick();

    // Zero-wait load
    idle(); ex_en = 1'b1; ex_memory_rd_en = 1'b1; dmem_ack = 1'b1; look();
    check("zw_req", 64'(dmem_req), 64'h1);
    check("zw_stl", 64'(stl), 64'h0);
    tick();
    idle(); look();
    check("zw_after", 64'(stl), 64'h0);

    // Three-cycle load: stalled cycles are the RUN entry and wait cycles 1,2
    ex_en = 1'b1; ex_memory_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      check($sformatf("ld3_stl%0d", i), 64'(stl), 64'b11110);
      check($sformatf("ld3_fl%0d", i), 64'(fl), 64'b0001);
      tick();
    end
    dmem_ack = 1'b1; look();
    check("ld3_ack_stl", 64'(stl), 64'h0);
    check("ld3_ack_req", 64'(dmem_req), 64'h1);
    tick();
    idle(); load_use(5'd5, 1'b0); look();
    check("ld3_run", 64'(stl), 64'b11000);
    tick();

    // Store timeout
    idle(); ex_en = 1'b1; ex_memory_we_en = 1'b1; ex_pc = 32'h1234; look();
    check("to_entry", 64'(stl), 64'b11110);
    tick();
    for (int i = 1; i <= 15; i++) begin
      look();
      check($sformatf("to_wait%0d", i), 64'(stl), 64'b11110);
      tick();
    end
    look();
    check("to_fl", 64'(fl), 64'b1111);
    check("to_req", 64'(dmem_req), 64'h0);
    tick();
    idle(); look();
    check("to_trap_req", 64'(trap_req), 64'h1);
    check("to_cause", 64'(trap_cause), 64'd7);
    check("to_pc", 64'(trap_pc), 64'h1234);
    check("to_tw_stl", 64'(stl), 64'b11111);
    tick();
    trap_ack = 1'b1; look();
    check("to_ack_stl", 64'(stl), 64'b11111);
    tick();
    idle(); look();
    check("to_clr_req", 64'(trap_req), 64'h0);
    check("to_clr_stl", 64'(stl), 64'h0);

    // Ecall beats a taken branch
    ex_en = 1'b1; ex_ecall_en = 1'b1; ex_pc = 32'h80;
    id_en = 1'b1; id_branch_taken = 1'b1; look();
    check("ec_fl", 64'(fl), 64'b1111);
    check("ec_stl", 64'(stl), 64'b10000);
    tick();
    idle(); look();
    check("ec_req", 64'(trap_req), 64'h1);
    check("ec_cause", 64'(trap_cause), 64'd11);
    check("ec_pc", 64'(trap_pc), 64'h80);
    trap_ack = 1'b1; tick();
    idle();

    // Debug halt and resume
    ex_en = 1'b1; ex_ebreak_en = 1'b1; dbg_halt_en = 1'b1; ex_pc = 32'h44; tick();
    idle(); look();
    check("hl_halted", 64'(halted), 64'h1);
    check("hl_req", 64'(trap_req), 64'h0);
    check("hl_stl", 64'(stl), 64'b11111);
    tick(); look();
    check("hl_hold", 64'(halted), 64'h1);
    dbg_resume = 1'b1; tick();
    idle(); look();
    check("hl_resumed", 64'(halted), 64'h0);
    check("hl_run_stl", 64'(stl), 64'h0);

    // Ebreak without halt, with ecall and exception also set
    ex_en = 1'b1; ex_ebreak_en = 1'b1; ex_ecall_en = 1'b1; ex_exp_code = 4'h1; tick();
    idle(); look();
    check("eb_req", 64'(trap_req), 64'h1);
    check("eb_cause", 64'(trap_cause), 64'd3);
    check("eb_halted", 64'(halted), 64'h0);
    trap_ack = 1'b1; tick();
    idle(); ex_en = 1'b1; ex_exp_code = 4'h2; ex_pc = 32'h90; tick();
    idle(); look();
    check("exp_cause", 64'(trap_cause), 64'd2);
    check("exp_pc", 64'(trap_pc), 64'h90);
    trap_ack = 1'b1; tick();
    idle(); ex_ecall_en = 1'b1; look();
    check("noen_stl", 64'(stl), 64'h0);
    tick();
    idle();

    // Reset at wait cycle 5
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; tick();
    for (int i = 1; i < 5; i++) tick();
    look();
    check("rm_pre_stl", 64'(stl), 64'b11110);
    rst_n = 1'b0; #1;
    check("rm_req", 64'(dmem_req), 64'h0);
    check("rm_stl", 64'(stl), 64'h0);
    check("rm_trap_req", 64'(trap_req), 64'h0);
    idle(); #1;
    rst_n = 1'b1;
    tick();
    load_use(5'd5, 1'b0); look();
    check("rm_run", 64'(stl), 64'b11000);
    tick();

    // cpu_en low freezes the wait counter
    idle(); ex_en = 1'b1; ex_memory_we_en = 1'b1; ex_pc = 32'h200; tick();
    tick();
    cpu_en = 1'b0; look();
    check("ce_req", 64'(dmem_req), 64'h0);
    check("ce_stl", 64'(stl), 64'b11110);
    for (int i = 0; i < 5; i++) tick();
    cpu_en = 1'b1;
    n = 0;
    look();
    while (fl != 4'b1111 && n < 40) begin
      tick(); look();
      n++;
    end
    check("ce_frozen_cnt", 64'(n), 64'd14);
    tick();
    idle(); look();
    check("ce_cause", 64'(trap_cause), 64'd7);
    check("ce_pc", 64'(trap_pc), 64'h200);
    trap_ack = 1'b1; tick();
    idle(); look();
    check("ce_done", 64'(trap_req), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline. Drives the per-register stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four hazard classes: load-use hazards, taken-branch redirects, multi-cycle data-memory accesses with timeout, and exception/ecall/ebreak trap entry.
- Runs a small FSM that holds the pipeline while the data bus, the CSR trap unit or the debugger owns it.

Parameters:
- MEM_TIMEOUT, 16: number of MEM_WAIT cycles without dmem_ack before an access fault is raised. Range 2..255.
- CNT_WIDTH, 8: width of the wait counter. Must satisfy 2^CNT_WIDTH > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  global enable; when low, FSM, counter and trap registers hold
- if_rs1_addr, if_rs2_addr  in  GPR_ADDR_WIDTH each  source registers of the instruction in IF/ID
- if_rs1_used, if_rs2_used  in  1 each  source operand is actually read
- id_en  in  1  ID/EX holds a valid instruction
- id_is_load  in  1  ID/EX instruction is a load
- id_gpr_we_n  in  1  ID/EX GPR write enable (GPR_WRITE active)
- id_dst_addr  in  GPR_ADDR_WIDTH  ID/EX destination register
- id_branch_taken  in  1  branch/jump in ID/EX resolved taken this cycle
- ex_en  in  1  EX/MEM holds a valid instruction
- ex_memory_rd_en, ex_memory_we_en  in  1 each  load / store pending in EX/MEM
- ex_exp_code  in  DATA_WIDTH_ISA_EXP  nonzero means decode exception
- ex_ecall_en, ex_ebreak_en  in  1 each  ecall / ebreak in EX/MEM
- ex_pc  in  PC_WIDTH  PC of the EX/MEM instruction
- dmem_ack  in  1  data bus completes the access this cycle
- trap_ack  in  1  CSR unit has taken the trap and redirected the PC
- dbg_halt_en  in  1  ebreak enters halt instead of trapping
- dbg_resume  in  1  leave halt
- pc_stall, if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding register
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  load a bubble into the corresponding register
- dmem_req  out  1  data access request
- trap_req  out  1  registered trap request to the CSR unit
- trap_cause  out  4  registered mcause code
- trap_pc  out  PC_WIDTH  registered faulting PC (mepc)
- halted  out  1  registered debug-halt flag

Behaviour:

Reset and timing
- Reset: state RUN, counter 0, trap_req 0, trap_cause 0, trap_pc 0, halted 0.
- Stall, flush and dmem_req are combinational from the current state and inputs. All are 0 in RUN with idle inputs.
- cpu_en low: dmem_req is forced 0; FSM, counter and registered outputs hold.

States: RUN, MEM_WAIT, TRAP_WAIT, HALT.

RUN, evaluated in priority order (first matching rule applies):
1. Trap: ex_en and (ex_exp_code≠0, ex_ecall_en or ex_ebreak_en).
   - Assert pc_stall, if_flush, id_flush, ex_flush, mem_flush. dmem_req = 0.
   - Latch trap_pc = ex_pc and trap_cause: ebreak 3, ecall 11, ex_exp_code 2. If several are set, ebreak wins, then ecall.
   - If ebreak and dbg_halt_en: next state HALT, halted←1, no trap_req.
   - Otherwise: trap_req←1, next state TRAP_WAIT.
2. Memory access: ex_en and (rd or we).
   - dmem_req = 1.
   - If dmem_ack is high in the same cycle: zero-wait, no stall.
   - Otherwise: assert pc_stall, if_stall, id_stall, ex_stall and mem_flush; counter←1; next state MEM_WAIT.
3. Taken branch: id_branch_taken and id_en.
   - Assert if_flush and id_flush (two wrong-path slots).
   - Suppresses load-use detection in the same cycle.
4. Load-use: id_en, id_is_load, id_gpr_we_n=GPR_WRITE, id_dst_addr≠0, and id_dst_addr matches a used rs.
   - Assert pc_stall, if_stall, id_flush: exactly one bubble, then normal flow.

MEM_WAIT
- Keep dmem_req=1, pc/if/id/ex stalls and mem_flush asserted.
- dmem_ack: all stalls drop in that same cycle; counter←0; next state RUN. A branch held in ID/EX is re-evaluated in RUN.
- counter==MEM_TIMEOUT without ack:
  - dmem_req=0.
  - Flush if, id, ex and mem.
  - trap_cause 5 (load) or 7 (store); trap_pc=ex_pc; trap_req←1; next state TRAP_WAIT.
- Otherwise: counter+1. An ack arriving in the timeout cycle wins over the fault.

TRAP_WAIT
- pc/if/id/ex/mem stalls all asserted.
- On trap_ack: trap_req←0, next state RUN, next cycle unstalled.

HALT
- All stalls asserted, halted=1.
- On dbg_resume: halted←0, next state RUN.

General
- mem_stall is asserted only in TRAP_WAIT and HALT.
- Asynchronous reset in any state returns to the reset values immediately, including dropping dmem_req.

Test Plan:
1. Load-use: ID/EX holds lw x5 (we, id_dst_addr=5) and IF/ID reads rs1=5 with rs1 used -> exactly one cycle of pc_stall=if_stall=id_flush=1. Same case with id_dst_addr=0 -> no stall.
2. Zero-wait and 3-cycle loads: with dmem_ack high in the same cycle -> no stall. With ack on the 3rd wait cycle -> pc/if/id/ex_stall high for exactly 3 cycles, mem_flush high for the same cycles, state returns to RUN.
3. Timeout: a store with no ack and MEM_TIMEOUT=16 -> after 16 MEM_WAIT cycles all flushes assert, trap_req=1, trap_cause=7, trap_pc=ex_pc. trap_ack two cycles later -> RUN, trap_req=0.
4. Trap priority: ecall at ex_pc=0x80 in the same cycle as id_branch_taken -> if/id/ex/mem_flush=1, trap_cause=11, trap_pc=0x80; branch ignored.
5. Debug halt: ebreak with dbg_halt_en=1 -> halted=1, all stalls high, no trap_req. dbg_resume -> RUN. Same ebreak with dbg_halt_en=0 -> trap_cause=3.
6. Reset mid-MEM_WAIT: assert rst_n low at wait cycle 5 -> dmem_req, stalls and trap_req drop asynchronously; state RUN after release. Also drop cpu_en in MEM_WAIT -> counter frozen.
